// File: rtl/readout_rx_integration_window_ctrl_google.sv
// Measurement window controller: drops ring-up samples after a trigger, then
// forwards a fixed number of I/Q samples framed by start/finish pulses.
module readout_rx_integration_window_ctrl_google #(
    parameter int DATA_WIDTH     = 8,
    parameter int COUNT_WIDTH    = 10,
    parameter int CFG_ADDR_WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_wr_en,
    input  logic [CFG_ADDR_WIDTH-1:0]    cfg_wr_addr,
    input  logic [COUNT_WIDTH-1:0]       cfg_wr_data,
    input  logic                         meas_trigger,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] i_in,
    input  logic signed [DATA_WIDTH-1:0] q_in,
    output logic                         valid_out,
    output logic signed [DATA_WIDTH-1:0] i_out,
    output logic signed [DATA_WIDTH-1:0] q_out,
    output logic                         start_count,
    output logic                         finish_count,
    output logic                         busy,
    output logic                         trigger_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_START,
        S_INTEG,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                         state_q, state_d;
    logic [COUNT_WIDTH-1:0]         delay_q, length_q;
    logic [COUNT_WIDTH-1:0]         dly_snap_q, dly_snap_d;
    logic [COUNT_WIDTH-1:0]         len_snap_q, len_snap_d;
    logic [COUNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0]         cnt_inc;
    logic                           ovr_q, ovr_d;
    logic                           gate;
    logic                           vld_p1_q;
    logic signed [DATA_WIDTH-1:0]   i_p1_q, q_p1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delay_q  <= '0;
            length_q <= COUNT_WIDTH'(1);
        end else if (cfg_wr_en) begin
            if (cfg_wr_addr == CFG_ADDR_WIDTH'(0)) begin
                delay_q <= cfg_wr_data;
            end else if (cfg_wr_addr == CFG_ADDR_WIDTH'(1)) begin
                length_q <= cfg_wr_data;
            end
        end
    end

    assign cnt_inc = cnt_q + COUNT_WIDTH'(1);
    assign gate    = valid_in && ((state_q == S_START) || (state_q == S_INTEG));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dly_snap_d = dly_snap_q;
        len_snap_d = len_snap_q;
        ovr_d      = 1'b0;
        unique case (state_q)
            S_IDLE, S_FINISH: begin
                if (meas_trigger) begin
                    dly_snap_d = delay_q;
                    len_snap_d = (length_q == '0) ? COUNT_WIDTH'(1) : length_q;
                    cnt_d      = '0;
                    state_d    = (delay_q == '0) ? S_START : S_DELAY;
                end else if (state_q == S_FINISH) begin
                    state_d = S_IDLE;
                end
            end
            S_DELAY: begin
                ovr_d = meas_trigger;
                if (valid_in) begin
                    // Counter is reused for the window once the delay is met
                    if (cnt_inc == dly_snap_q) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_START, S_INTEG: begin
                ovr_d = meas_trigger;
                if (state_q == S_START) begin
                    state_d = S_INTEG;
                end
                if (valid_in) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_snap_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                ovr_d   = meas_trigger;
                state_d = S_FINISH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dly_snap_q <= '0;
            len_snap_q <= COUNT_WIDTH'(1);
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dly_snap_q <= dly_snap_d;
            len_snap_q <= len_snap_d;
            ovr_q      <= ovr_d;
        end
    end

    // Stage p1: gated sample register, holds between strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q <= 1'b0;
            i_p1_q   <= '0;
            q_p1_q   <= '0;
        end else begin
            vld_p1_q <= gate;
            if (gate) begin
                i_p1_q <= i_in;
                q_p1_q <= q_in;
            end
        end
    end

    assign valid_out       = vld_p1_q;
    assign i_out           = i_p1_q;
    assign q_out           = q_p1_q;
    assign start_count     = (state_q == S_START);
    assign finish_count    = (state_q == S_FINISH);
    assign busy            = (state_q != S_IDLE);
    assign trigger_overrun = ovr_q;

endmodule

// File: tb/tb_readout_rx_integration_window_ctrl_google.sv
// Directed bench with an I/Q scoreboard for the integration window controller.
module tb_readout_rx_integration_window_ctrl_google;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_wr_en = 1'b0;
    logic [0:0]        cfg_wr_addr = '0;
    logic [9:0]        cfg_wr_data = '0;
    logic              meas_trigger = 1'b0;
    logic              valid_in = 1'b0;
    logic signed [7:0] i_in = '0;
    logic signed [7:0] q_in = '0;
    logic              valid_out;
    logic signed [7:0] i_out, q_out;
    logic              start_count, finish_count, busy, trigger_overrun;

    readout_rx_integration_window_ctrl_google #(
        .DATA_WIDTH(8), .COUNT_WIDTH(10), .CFG_ADDR_WIDTH(1)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .meas_trigger(meas_trigger), .valid_in(valid_in), .i_in(i_in), .q_in(q_in),
        .valid_out(valid_out), .i_out(i_out), .q_out(q_out),
        .start_count(start_count), .finish_count(finish_count),
        .busy(busy), .trigger_overrun(trigger_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    int start_cnt = 0, fin_cnt = 0, vout_cnt = 0, ovr_cnt = 0;
    int last_start_cyc = -1, last_fin_cyc = -1, last_vout_cyc = -1, last_ovr_cyc = -1;
    int busy_rise_cyc = -1, busy_fall_cyc = -1;
    int s_start, s_fin, s_vout, s_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each valid_out and tracks event cycles
    initial begin : monitor
        logic [15:0] last_io;
        logic [15:0] exp_io;
        logic        busy_prev;
        last_io   = '0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_io = '0;
            end else begin
                if (busy && !busy_prev) busy_rise_cyc = cyc;
                if (!busy && busy_prev) busy_fall_cyc = cyc;
                if (start_count) begin start_cnt++; last_start_cyc = cyc; end
                if (trigger_overrun) begin ovr_cnt++; last_ovr_cyc = cyc; end
                if (valid_out) begin
                    vout_cnt++;
                    last_vout_cyc = cyc;
                    chk("sb_nonempty", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        exp_io = sb.pop_front();
                        chk("sample_iq", {16'h0, i_out, q_out}, {16'h0, exp_io});
                        last_io = {i_out, q_out};
                    end
                end else begin
                    chk("hold_iq", {16'h0, i_out, q_out}, {16'h0, last_io});
                end
                if (finish_count) begin
                    fin_cnt++;
                    last_fin_cyc = cyc;
                    chk("fin_after_vout", last_vout_cyc, cyc - 1);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic v, input logic fwd);
        valid_in = v;
        i_in     = 8'($urandom);
        q_in     = 8'($urandom);
        if (v && fwd) sb.push_back({i_in, q_in});
    endtask

    task automatic cfg_write(input logic a, input int d);
        step();
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = 10'(d);
        step();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic snap();
        s_start = start_cnt; s_fin = fin_cnt; s_vout = vout_cnt; s_ovr = ovr_cnt;
    endtask

    // Trigger, then drive ncyc cycles; the n-th valid after the trigger is
    // expected at the output when d < n <= d+L.
    task automatic run_window(input int d, input int L, input int period, input int ncyc,
                              input int trig_k, input int wr_k, input logic wr_a,
                              input int wr_d, output int t0);
        int n;
        logic v;
        n = 0;
        step();
        t0 = cyc;
        meas_trigger = 1'b1;
        drive_sample(period == 1, 1'b0);
        for (int k = 1; k <= ncyc; k++) begin
            step();
            meas_trigger = (k == trig_k);
            cfg_wr_en    = (k == wr_k);
            cfg_wr_addr  = wr_a;
            cfg_wr_data  = 10'(wr_d);
            v = ((k % period) == 0);
            if (v) n++;
            drive_sample(v, (n > d) && (n <= d + L));
        end
        step();
        meas_trigger = 1'b0;
        cfg_wr_en    = 1'b0;
        valid_in     = 1'b0;
    endtask

    task automatic check_win(input string tag, input int t0, input int st_off, input int nv,
                             input int fin_off, input int fall_off, input int novr);
        chk({tag, "_start_cyc"}, last_start_cyc, t0 + st_off);
        chk({tag, "_start_n"}, start_cnt - s_start, 1);
        chk({tag, "_vout_n"}, vout_cnt - s_vout, nv);
        chk({tag, "_fin_n"}, fin_cnt - s_fin, 1);
        chk({tag, "_fin_cyc"}, last_fin_cyc, t0 + fin_off);
        chk({tag, "_busy_rise"}, busy_rise_cyc, t0 + 1);
        chk({tag, "_busy_fall"}, busy_fall_cyc, t0 + fall_off);
        chk({tag, "_ovr_n"}, ovr_cnt - s_ovr, novr);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin : stimulus
        int t;
        repeat (3) step();
        chk("rst_valid_out", valid_out, 0);
        chk("rst_i_out", i_out, 0);
        chk("rst_q_out", q_out, 0);
        chk("rst_start", start_count, 0);
        chk("rst_finish", finish_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", trigger_overrun, 0);
        step();
        rst = 1'b1;
        repeat (2) step();

        cfg_write(1'b0, 3);
        cfg_write(1'b1, 4);
        snap();
        run_window(3, 4, 1, 14, 0, 0, 1'b0, 0, t);
        check_win("basic", t, 4, 4, 9, 10, 0);

        cfg_write(1'b0, 0);
        cfg_write(1'b1, 1);
        snap();
        run_window(0, 1, 1, 6, 0, 0, 1'b0, 0, t);
        check_win("minimal", t, 1, 1, 3, 4, 0);

        cfg_write(1'b0, 2);
        cfg_write(1'b1, 3);
        snap();
        run_window(2, 3, 2, 14, 0, 0, 1'b0, 0, t);
        check_win("sparse", t, 5, 3, 12, 13, 0);

        cfg_write(1'b0, 0);
        cfg_write(1'b1, 4);
        snap();
        run_window(0, 4, 1, 10, 2, 0, 1'b0, 0, t);
        check_win("overrun", t, 1, 4, 6, 7, 1);
        chk("overrun_cyc", last_ovr_cyc, t + 3);

        cfg_write(1'b1, 2);
        snap();
        step();
        t = cyc;
        meas_trigger = 1'b1;
        drive_sample(1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            meas_trigger = (k == 4);
            drive_sample(k == 1 || k == 2 || k == 5 || k == 6, 1'b1);
        end
        step();
        meas_trigger = 1'b0;
        valid_in = 1'b0;
        chk("b2b_start_n", start_cnt - s_start, 2);
        chk("b2b_start_cyc", last_start_cyc, t + 5);
        chk("b2b_vout_n", vout_cnt - s_vout, 4);
        chk("b2b_fin_n", fin_cnt - s_fin, 2);
        chk("b2b_fin_cyc", last_fin_cyc, t + 8);
        chk("b2b_ovr_n", ovr_cnt - s_ovr, 0);
        chk("b2b_busy_rise", busy_rise_cyc, t + 1);
        chk("b2b_busy_fall", busy_fall_cyc, t + 9);
        chk("b2b_sb_empty", sb.size(), 0);

        cfg_write(1'b0, 1);
        cfg_write(1'b1, 4);
        snap();
        run_window(1, 4, 1, 12, 0, 3, 1'b1, 8, t);
        check_win("iso_first", t, 2, 4, 7, 8, 0);
        snap();
        run_window(1, 8, 1, 16, 0, 0, 1'b0, 0, t);
        check_win("iso_second", t, 2, 8, 11, 12, 0);

        snap();
        step();
        meas_trigger = 1'b1;
        drive_sample(1'b0, 1'b0);
        step();
        meas_trigger = 1'b0;
        drive_sample(1'b1, 1'b0);
        step();
        drive_sample(1'b1, 1'b1);
        step();
        drive_sample(1'b1, 1'b0);
        step();
        valid_in = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_valid_out", valid_out, 0);
        chk("abort_i_out", i_out, 0);
        chk("abort_q_out", q_out, 0);
        chk("abort_start", start_count, 0);
        chk("abort_finish", finish_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ovr", trigger_overrun, 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();
        chk("abort_fin_n", fin_cnt - s_fin, 0);
        chk("abort_vout_n", vout_cnt - s_vout, 1);
        chk("abort_sb_empty", sb.size(), 0);

        snap();
        run_window(0, 1, 1, 6, 0, 0, 1'b0, 0, t);
        check_win("post_reset", t, 1, 1, 3, 4, 0);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
